// File: rtl/mdu_seq.sv
// Multi-cycle shift-add multiplier / restoring divider driving an external ALU.
// Divide datapath present only when MDU_DIV_EN is defined.
module mdu_seq #(
  parameter int DATA_WITH = 16,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [DATA_WITH-1:0] opa,
  input  logic [DATA_WITH-1:0] opb,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_WITH-1:0] hi,
  output logic [DATA_WITH-1:0] lo,
  output logic                 div_by_zero,
  output logic [DATA_WITH-1:0] alu_rega,
  output logic [DATA_WITH-1:0] alu_regb,
  output logic [OP_SIZE-1:0]   alu_control,
  input  logic [DATA_WITH-1:0] alu_out
);

  localparam int CW = $clog2(DATA_WITH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_SIZE-1:0] ALU_ADD = OP_SIZE'(0);
`ifdef MDU_DIV_EN
  localparam logic [OP_SIZE-1:0] ALU_SUB = OP_SIZE'(1);
`endif

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_WITH-1:0] hi_q, hi_d;
  logic [DATA_WITH-1:0] lo_q, lo_d;
  logic [DATA_WITH-1:0] b_q, b_d;

  logic [DATA_WITH-1:0] mul_s;
  logic                 mul_c;

  assign mul_s = lo_q[0] ? alu_out : hi_q;
  assign mul_c = lo_q[0] & (alu_out < hi_q);

`ifdef MDU_DIV_EN
  logic                 op_q, op_d;
  logic                 dbz_q, dbz_d;
  logic [DATA_WITH-1:0] div_r;
  logic                 div_m;
  logic                 qbit;

  // m=1 means the shifted remainder overflowed W bits, so it exceeds B
  assign div_r = {hi_q[DATA_WITH-2:0], lo_q[DATA_WITH-1]};
  assign div_m = hi_q[DATA_WITH-1];
  assign qbit  = div_m | (div_r >= b_q);
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    alu_rega    = '0;
    alu_regb    = '0;
    alu_control = ALU_ADD;
`ifdef MDU_DIV_EN
    op_d        = op_q;
    dbz_d       = dbz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hi_d = '0;
`ifdef MDU_DIV_EN
          op_d  = op;
          dbz_d = 1'b0;
          if (op && (opb == '0)) begin
            hi_d    = opa;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else if (op) begin
            b_d     = opb;
            lo_d    = opa;
            count_d = CW'(DATA_WITH);
            state_d = S_RUN;
          end else begin
`else
          if (op) begin
            lo_d    = '0;
            state_d = S_DONE;
          end else begin
`endif
            b_d     = opa;
            lo_d    = opb;
            count_d = CW'(DATA_WITH);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        alu_rega     = hi_q;
        alu_regb     = b_q;
        {hi_d, lo_d} = {mul_c, mul_s, lo_q[DATA_WITH-1:1]};
`ifdef MDU_DIV_EN
        if (op_q) begin
          alu_rega    = div_r;
          alu_control = ALU_SUB;
          hi_d        = qbit ? alu_out : div_r;
          lo_d        = {lo_q[DATA_WITH-2:0], qbit};
        end
`endif
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
`ifdef MDU_DIV_EN
      op_q    <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
`ifdef MDU_DIV_EN
      op_q    <= op_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_DONE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural 16-bit ALU model.
module tb_mdu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo, alu_rega, alu_regb, alu_out;
  logic [3:0]   alu_control;

  int passed = 0;
  int total = 0;
  int sub_seen = 0;

  mdu_seq #(.DATA_WITH(W), .OP_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .opa(opa), .opb(opb), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_control(alu_control), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  assign alu_out = (alu_control == 4'd1) ? (alu_rega - alu_regb)
                                         : (alu_rega + alu_regb);

  always @(posedge clk)
    if (alu_control == 4'd1) sub_seen <= sub_seen + 1;

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t tv[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start = 1'b1;
    op    = v.op;
    opa   = v.a;
    opb   = v.b;
    step();
    start = 1'b0;
    opa   = ~v.a;
    opb   = ~v.b;
    n = 1;
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk({v.name, " latency"}, 32'(n), 32'(v.lat));
    chk({v.name, " hi"}, 32'(hi), 32'(v.hi));
    chk({v.name, " lo"}, 32'(lo), 32'(v.lo));
    chk({v.name, " dbz"}, 32'(div_by_zero), 32'(v.dbz));
    step();
    chk({v.name, " done pulse"}, {31'd0, done}, 32'd0);
    chk({v.name, " idle busy"}, {31'd0, busy}, 32'd0);
    chk({v.name, " hi hold"}, 32'(hi), 32'(v.hi));
    chk({v.name, " idle alu"}, {alu_control, alu_rega, alu_regb[11:0]},
        {4'd0, 16'd0, 12'd0});
  endtask

  initial begin
    int ndone;

    tv[0] = '{"mul1234", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17};
    tv[1] = '{"mulFFFF", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    tv[2] = '{"mulzero", 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
`ifdef MDU_DIV_EN
    tv[3] = '{"div7", 1'b1, 16'hFFFF, 16'h0007, 16'h0001, 16'h2492, 1'b0, 17};
    tv[4] = '{"div8001", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17};
    tv[5] = '{"div0", 1'b1, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1, 1};
`else
    tv[3] = '{"div7", 1'b1, 16'hFFFF, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1};
    tv[4] = '{"div8001", 1'b1, 16'hFFFF, 16'h8001, 16'h0000, 16'h0000, 1'b0, 1};
    tv[5] = '{"div0", 1'b1, 16'h00AB, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
`endif
    tv[6] = '{"mul3x5", 1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17};
    tv[7] = '{"mul8000x2", 1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17};

    rst_n = 1'b0;
    step();
    step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hilo", {hi, lo}, 32'd0);
    chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // start held high for the whole operation, operands changed mid-run
    start = 1'b1;
    op    = 1'b0;
    opa   = 16'h1234;
    opb   = 16'h5678;
    step();
    opa   = 16'h00FF;
    opb   = 16'h0101;
    ndone = 0;
    for (int n = 1; n < 40 && !done; n++) step();
    chk("hold hi", 32'(hi), 32'h0626);
    chk("hold lo", 32'(lo), 32'h0060);
    for (int k = 0; k < 4; k++) begin
      if (done) ndone++;
      step();
      if (k == 0) start = 1'b0;
    end
    chk("hold one done", 32'(ndone), 32'd1);
    chk("hold no reaccept", {31'd0, busy}, 32'd0);

    // reset in the middle of a multiply
    start = 1'b1;
    opa   = 16'h1234;
    opb   = 16'h5678;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("midrun busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst hilo", {hi, lo}, 32'd0);
    step();
    run_vec(tv[0]);

`ifdef MDU_DIV_EN
    chk("sub issued", {31'd0, (sub_seen != 0)}, 32'd1);
`else
    chk("sub never", 32'(sub_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
